prf_read_stage: RTL and testbench

Parametrised integer physical-register-file read stage sitting between the issue queues and the execution units. It accepts up to NUM_CH source-operand read requests per cycle and returns operand values one cycle later, alongside an opaque per-channel payload. It accepts NUM_WR result writes per cycle, with same-cycle write-to-read forwarding and a hard-wired zero register p0. Each channel has its own stall skid buffer; unlike the previous generation, the upstream stall is held through the release cycle so that no operation is dropped.

---
 rtl/prf_read_stage.sv | 155 +++++++++++++++
 tb/tb_prf_read_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_read_stage.sv
// Physical register file read stage: NUM_CH dual-operand read channels with
// per-channel stall skid entries, NUM_WR write ports with same-cycle forwarding.
module prf_read_stage #(
  parameter int XLEN        = 64,
  parameter int NUM_PHYREGS = 64,
  parameter int NUM_CH      = 4,
  parameter int NUM_WR      = 4,
  parameter int PAYLOAD_W   = 128,
  localparam int IDX_W      = $clog2(NUM_PHYREGS)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_CH-1:0]             in_valid,
  input  logic [NUM_CH*IDX_W-1:0]       in_rs1,
  input  logic [NUM_CH*IDX_W-1:0]       in_rs2,
  input  logic [NUM_CH*PAYLOAD_W-1:0]   in_payload,
  input  logic [NUM_CH-1:0]             stall_in,
  output logic [NUM_CH-1:0]             stall_out,
  output logic [NUM_CH-1:0]             out_valid,
  output logic [NUM_CH*XLEN-1:0]        out_rs1_val,
  output logic [NUM_CH*XLEN-1:0]        out_rs2_val,
  output logic [NUM_CH*PAYLOAD_W-1:0]   out_payload,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR*IDX_W-1:0]       wr_idx,
  input  logic [NUM_WR*XLEN-1:0]        wr_data,
  input  logic                          flush_in
);

  logic [XLEN-1:0]           r_regs     [NUM_PHYREGS];
  logic [NUM_CH-1:0]         r_pend_v;
  logic [IDX_W-1:0]          r_pend_rs1 [NUM_CH];
  logic [IDX_W-1:0]          r_pend_rs2 [NUM_CH];
  logic [PAYLOAD_W-1:0]      r_pend_pay [NUM_CH];
  logic [NUM_CH-1:0]         r_out_valid;
  logic [NUM_CH*XLEN-1:0]    r_out_rs1;
  logic [NUM_CH*XLEN-1:0]    r_out_rs2;
  logic [NUM_CH*PAYLOAD_W-1:0] r_out_pay;

  logic [NUM_CH-1:0]         w_sel_v;
  logic [IDX_W-1:0]          w_sel_rs1  [NUM_CH];
  logic [IDX_W-1:0]          w_sel_rs2  [NUM_CH];
  logic [PAYLOAD_W-1:0]      w_sel_pay  [NUM_CH];
  logic [XLEN-1:0]           w_rd1      [NUM_CH];
  logic [XLEN-1:0]           w_rd2      [NUM_CH];

  assign stall_out   = stall_in | r_pend_v;
  assign out_valid   = r_out_valid;
  assign out_rs1_val = r_out_rs1;
  assign out_rs2_val = r_out_rs2;
  assign out_payload = r_out_pay;

  // Per-channel op select: flush, then stall capture/hold, then pending release, then live.
  always_comb begin
    w_sel_v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel_rs1[c] = in_rs1[c*IDX_W +: IDX_W];
      w_sel_rs2[c] = in_rs2[c*IDX_W +: IDX_W];
      w_sel_pay[c] = in_payload[c*PAYLOAD_W +: PAYLOAD_W];
      if (flush_in) begin
        w_sel_v[c] = 1'b0;
      end else if (stall_in[c]) begin
        w_sel_v[c] = 1'b0;
      end else if (r_pend_v[c]) begin
        w_sel_v[c]   = 1'b1;
        w_sel_rs1[c] = r_pend_rs1[c];
        w_sel_rs2[c] = r_pend_rs2[c];
        w_sel_pay[c] = r_pend_pay[c];
      end else begin
        w_sel_v[c] = in_valid[c];
      end
    end
  end

  // Operand read with forwarding; ascending port scan lets the highest port win.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_rd1[c] = r_regs[w_sel_rs1[c]];
      w_rd2[c] = r_regs[w_sel_rs2[c]];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] == w_sel_rs1[c])) begin
          w_rd1[c] = wr_data[w*XLEN +: XLEN];
        end else begin
          w_rd1[c] = w_rd1[c];
        end
        if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] == w_sel_rs2[c])) begin
          w_rd2[c] = wr_data[w*XLEN +: XLEN];
        end else begin
          w_rd2[c] = w_rd2[c];
        end
      end
      if (w_sel_rs1[c] == '0) begin
        w_rd1[c] = '0;
      end else begin
        w_rd1[c] = w_rd1[c];
      end
      if (w_sel_rs2[c] == '0) begin
        w_rd2[c] = '0;
      end else begin
        w_rd2[c] = w_rd2[c];
      end
    end
  end

  // Register file storage; p0 is never written so it stays zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PHYREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] != '0)) begin
          r_regs[wr_idx[w*IDX_W +: IDX_W]] <= wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Skid entries and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_v    <= '0;
      r_out_valid <= '0;
      r_out_rs1   <= '0;
      r_out_rs2   <= '0;
      r_out_pay   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_pend_rs1[c] <= '0;
        r_pend_rs2[c] <= '0;
        r_pend_pay[c] <= '0;
      end
    end else begin
      r_out_valid <= w_sel_v;
      for (int c = 0; c < NUM_CH; c++) begin
        r_out_rs1[c*XLEN +: XLEN]           <= w_rd1[c];
        r_out_rs2[c*XLEN +: XLEN]           <= w_rd2[c];
        r_out_pay[c*PAYLOAD_W +: PAYLOAD_W] <= w_sel_pay[c];
        if (flush_in) begin
          r_pend_v[c] <= 1'b0;
        end else if (stall_in[c]) begin
          // Indices are kept, not values: the read happens at release.
          if (!r_pend_v[c] && in_valid[c]) begin
            r_pend_v[c]   <= 1'b1;
            r_pend_rs1[c] <= in_rs1[c*IDX_W +: IDX_W];
            r_pend_rs2[c] <= in_rs2[c*IDX_W +: IDX_W];
            r_pend_pay[c] <= in_payload[c*PAYLOAD_W +: PAYLOAD_W];
          end
        end else begin
          r_pend_v[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_read_stage.sv
// Randomized and directed bench for prf_read_stage against a register-array
// and skid-entry reference model.
module tb_prf_read_stage;
  localparam int XLEN = 64;
  localparam int NP   = 64;
  localparam int NC   = 4;
  localparam int NW   = 4;
  localparam int PW   = 128;
  localparam int IW   = 6;

  logic clock = 1'b0;
  logic reset_n;
  logic [NC-1:0]    in_valid, stall_in, stall_out, out_valid;
  logic [NC*IW-1:0] in_rs1, in_rs2;
  logic [NC*PW-1:0] in_payload, out_payload;
  logic [NC*XLEN-1:0] out_rs1_val, out_rs2_val;
  logic [NW-1:0]    wr_en;
  logic [NW*IW-1:0] wr_idx;
  logic [NW*XLEN-1:0] wr_data;
  logic flush_in;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [XLEN-1:0] mem [NP];
  logic [NC-1:0]   pv;
  logic [IW-1:0]   prs1 [NC];
  logic [IW-1:0]   prs2 [NC];
  logic [PW-1:0]   ppay [NC];
  logic [NC-1:0]   exp_v;
  logic [XLEN-1:0] exp_r1 [NC];
  logic [XLEN-1:0] exp_r2 [NC];
  logic [PW-1:0]   exp_p  [NC];

  always #5 clock = ~clock;

  prf_read_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_payload(in_payload), .stall_in(stall_in),
    .stall_out(stall_out), .out_valid(out_valid), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .out_payload(out_payload), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_data(wr_data), .flush_in(flush_in)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) mem[i] = '0;
    pv = '0;
    exp_v = '0;
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_rs1 = '0; in_rs2 = '0; in_payload = '0;
    stall_in = '0; wr_en = '0; wr_idx = '0; wr_data = '0; flush_in = 1'b0;
  endtask

  function automatic logic [IW-1:0] ridx();
    if ($urandom_range(0, 3) == 0) return IW'($urandom_range(0, NP-1));
    return IW'($urandom_range(0, 7));
  endfunction

  task automatic rand_inputs();
    for (int c = 0; c < NC; c++) begin
      in_valid[c] = ($urandom_range(0, 9) < 7);
      stall_in[c] = ($urandom_range(0, 9) < 3);
      in_rs1[c*IW +: IW] = ridx();
      in_rs2[c*IW +: IW] = ridx();
      in_payload[c*PW +: PW] = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int w = 0; w < NW; w++) begin
      wr_en[w] = ($urandom_range(0, 1) == 1);
      wr_idx[w*IW +: IW] = ridx();
      wr_data[w*XLEN +: XLEN] = {$urandom, $urandom};
    end
    flush_in = ($urandom_range(0, 99) < 3);
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic step();
    logic [XLEN-1:0] nm [NP];
    logic [IW-1:0] a;
    #1;
    for (int c = 0; c < NC; c++)
      chk($sformatf("stall_out%0d", c), 128'(stall_out[c]), 128'(stall_in[c] | pv[c]));
    nm = mem;
    for (int w = 0; w < NW; w++) begin
      a = wr_idx[w*IW +: IW];
      if (wr_en[w] && a != 0) nm[a] = wr_data[w*XLEN +: XLEN];
    end
    for (int c = 0; c < NC; c++) begin
      exp_v[c] = 1'b0;
      if (flush_in) begin
        pv[c] = 1'b0;
      end else if (stall_in[c]) begin
        if (!pv[c] && in_valid[c]) begin
          pv[c] = 1'b1;
          prs1[c] = in_rs1[c*IW +: IW];
          prs2[c] = in_rs2[c*IW +: IW];
          ppay[c] = in_payload[c*PW +: PW];
        end
      end else if (pv[c]) begin
        exp_v[c] = 1'b1;
        exp_r1[c] = nm[prs1[c]];
        exp_r2[c] = nm[prs2[c]];
        exp_p[c]  = ppay[c];
        pv[c] = 1'b0;
      end else if (in_valid[c]) begin
        exp_v[c] = 1'b1;
        exp_r1[c] = nm[in_rs1[c*IW +: IW]];
        exp_r2[c] = nm[in_rs2[c*IW +: IW]];
        exp_p[c]  = in_payload[c*PW +: PW];
      end
    end
    mem = nm;
    @(posedge clock);
    @(negedge clock);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("valid%0d", c), 128'(out_valid[c]), 128'(exp_v[c]));
      if (exp_v[c]) begin
        chk($sformatf("rs1_%0d", c), 128'(out_rs1_val[c*XLEN +: XLEN]), 128'(exp_r1[c]));
        chk($sformatf("rs2_%0d", c), 128'(out_rs2_val[c*XLEN +: XLEN]), 128'(exp_r2[c]));
        chk($sformatf("pay%0d", c), out_payload[c*PW +: PW], exp_p[c]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int c = 0; c < NC; c++) begin
      chk({tag, "_valid"}, 128'(out_valid[c]), 128'(1'b0));
      chk({tag, "_rs1"}, 128'(out_rs1_val[c*XLEN +: XLEN]), 128'(0));
      chk({tag, "_rs2"}, 128'(out_rs2_val[c*XLEN +: XLEN]), 128'(0));
      chk({tag, "_pay"}, out_payload[c*PW +: PW], 128'(0));
      chk({tag, "_stall"}, 128'(stall_out[c]), 128'(stall_in[c]));
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset_n = 1'b0;
    stall_in = 4'b0110;
    #1;
    check_reset_outputs("rst");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    clear_inputs();

    // Basic read after write
    wr_en[0] = 1'b1; wr_idx[0 +: IW] = 6'd5; wr_data[0 +: XLEN] = 64'hDEAD;
    step();
    clear_inputs();
    in_valid[0] = 1'b1; in_rs1[0 +: IW] = 6'd5; in_rs2[0 +: IW] = 6'd0;
    in_payload[0 +: PW] = 128'h1234_5678;
    step();
    chk("basic_v", 128'(out_valid[0]), 128'(1'b1));
    chk("basic_rs1", 128'(out_rs1_val[0 +: XLEN]), 128'(64'hDEAD));
    chk("basic_rs2", 128'(out_rs2_val[0 +: XLEN]), 128'(0));
    chk("basic_pay", out_payload[0 +: PW], 128'h1234_5678);

    // Same-cycle forwarding with highest-port priority
    clear_inputs();
    wr_en = 4'b1001;
    wr_idx[0 +: IW] = 6'd7;  wr_data[0 +: XLEN] = 64'h11;
    wr_idx[3*IW +: IW] = 6'd7; wr_data[3*XLEN +: XLEN] = 64'h33;
    in_valid[1] = 1'b1; in_rs1[1*IW +: IW] = 6'd7;
    step();
    chk("fwd_rs1", 128'(out_rs1_val[1*XLEN +: XLEN]), 128'(64'h33));
    clear_inputs();
    in_valid[2] = 1'b1; in_rs1[2*IW +: IW] = 6'd7;
    step();
    chk("fwd_later", 128'(out_rs1_val[2*XLEN +: XLEN]), 128'(64'h33));

    // p0 is hard-wired zero
    clear_inputs();
    wr_en[0] = 1'b1; wr_idx[0 +: IW] = 6'd0; wr_data[0 +: XLEN] = 64'hFFFF;
    in_valid[0] = 1'b1; in_rs1[0 +: IW] = 6'd0;
    step();
    chk("p0_fwd", 128'(out_rs1_val[0 +: XLEN]), 128'(0));
    clear_inputs();
    in_valid[0] = 1'b1; in_rs1[0 +: IW] = 6'd0;
    step();
    chk("p0_store", 128'(out_rs1_val[0 +: XLEN]), 128'(0));

    // Stall: A captured, p3 written while stalled, B held upstream
    clear_inputs();
    in_valid[0] = 1'b1; in_rs1[0 +: IW] = 6'd3; in_payload[0 +: PW] = 128'hA;
    stall_in[0] = 1'b1;
    step();
    chk("stall_v0", 128'(out_valid[0]), 128'(1'b0));
    in_rs1[0 +: IW] = 6'd5; in_payload[0 +: PW] = 128'hB;
    wr_en[1] = 1'b1; wr_idx[1*IW +: IW] = 6'd3; wr_data[1*XLEN +: XLEN] = 64'h42;
    step();
    chk("stall_v1", 128'(out_valid[0]), 128'(1'b0));
    wr_en = '0;
    step();
    stall_in[0] = 1'b0;
    #1;
    chk("release_stall_out", 128'(stall_out[0]), 128'(1'b1));
    step();
    chk("rel_A_v", 128'(out_valid[0]), 128'(1'b1));
    chk("rel_A_rs1", 128'(out_rs1_val[0 +: XLEN]), 128'(64'h42));
    chk("rel_A_pay", out_payload[0 +: PW], 128'hA);
    chk("rel_stall_drop", 128'(stall_out[0]), 128'(1'b0));
    step();
    chk("rel_B_rs1", 128'(out_rs1_val[0 +: XLEN]), 128'(64'hDEAD));
    chk("rel_B_pay", out_payload[0 +: PW], 128'hB);
    clear_inputs();
    step();
    chk("rel_no_dup", 128'(out_valid[0]), 128'(1'b0));

    // Flush with a pending op
    clear_inputs();
    in_valid[1] = 1'b1; in_rs1[1*IW +: IW] = 6'd5; stall_in[1] = 1'b1;
    step();
    flush_in = 1'b1;
    step();
    clear_inputs();
    #1;
    chk("flush_stall_out", 128'(stall_out[1]), 128'(1'b0));
    step();
    chk("flush_no_out", 128'(out_valid[1]), 128'(1'b0));
    in_valid[1] = 1'b1; in_rs1[1*IW +: IW] = 6'd5;
    step();
    chk("flush_rf_kept", 128'(out_rs1_val[1*XLEN +: XLEN]), 128'(64'hDEAD));

    // Randomized traffic
    repeat (800) begin
      rand_inputs();
      step();
    end

    // Async reset with ops in flight (ch2,3) and pending (ch0,1)
    clear_inputs();
    for (int c = 0; c < NC; c++) begin
      in_valid[c] = 1'b1;
      in_rs1[c*IW +: IW] = ridx();
      in_rs2[c*IW +: IW] = ridx();
      in_payload[c*PW +: PW] = {$urandom, $urandom, $urandom, $urandom};
    end
    stall_in = 4'b0011;
    step();
    stall_in = 4'b0100;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(negedge clock);
    check_reset_outputs("arst_hold");
    reset_n = 1'b1;
    clear_inputs();
    for (int c = 0; c < NC; c++) begin
      in_valid[c] = 1'b1;
      in_rs1[c*IW +: IW] = 6'd5;
      in_rs2[c*IW +: IW] = 6'd7;
    end
    step();
    chk("post_rst_rs1", 128'(out_rs1_val[0 +: XLEN]), 128'(0));
    chk("post_rst_rs2", 128'(out_rs2_val[3*XLEN +: XLEN]), 128'(0));

    repeat (800) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
